// File: rtl/conv_mul_arbiter.sv
// Round-robin arbiter feeding a shared 2-stage unsigned A x B multiplier.
// Results return on one port with backpressure, tagged with the requester index.
module conv_mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2,
    parameter int A_WIDTH  = 8,
    parameter int B_WIDTH  = 21,
    parameter int P_WIDTH  = 29
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [P_WIDTH-1:0]           rsp_p,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic [31:0]                  op_count
);

    logic [ID_WIDTH-1:0] ptr_r;
    logic                v1_r;
    logic [A_WIDTH-1:0]  a1_r;
    logic [B_WIDTH-1:0]  b1_r;
    logic [ID_WIDTH-1:0] id1_r;
    logic                v2_r;
    logic [P_WIDTH-1:0]  p2_r;
    logic [ID_WIDTH-1:0] id2_r;
    logic [31:0]         op_count_r;

    logic                stall_s;
    logic                accept_s;
    logic                grant_any_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_WIDTH-1:0] grant_id_s;
    logic [ID_WIDTH:0]   scan_s;
    logic [ID_WIDTH:0]   next_ptr_s;
    logic [A_WIDTH-1:0]  a_sel_s;
    logic [B_WIDTH-1:0]  b_sel_s;

    assign stall_s  = v2_r && !rsp_ready;
    assign accept_s = grant_any_s && !stall_s;

    // Round-robin scan starting at ptr; first valid requester wins.
    always_comb begin
        grant_s     = '0;
        grant_id_s  = '0;
        grant_any_s = 1'b0;
        scan_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_s = {1'b0, ptr_r} + (ID_WIDTH+1)'(k);
            if (scan_s >= (ID_WIDTH+1)'(NUM_REQ)) begin
                scan_s = scan_s - (ID_WIDTH+1)'(NUM_REQ);
            end else begin
                scan_s = scan_s;
            end
            if (!grant_any_s && req_valid[scan_s[ID_WIDTH-1:0]]) begin
                grant_s[scan_s[ID_WIDTH-1:0]] = 1'b1;
                grant_id_s  = scan_s[ID_WIDTH-1:0];
                grant_any_s = 1'b1;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                a_sel_s = req_a[i*A_WIDTH +: A_WIDTH];
                b_sel_s = req_b[i*B_WIDTH +: B_WIDTH];
            end else begin
                a_sel_s = a_sel_s;
            end
        end
    end

    // Pointer successor of the granted index, wrapping at NUM_REQ.
    always_comb begin
        next_ptr_s = {1'b0, grant_id_s} + {{ID_WIDTH{1'b0}}, 1'b1};
        if (next_ptr_s >= (ID_WIDTH+1)'(NUM_REQ)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = next_ptr_s;
        end
    end

    // Accept strobes are suppressed while stalled and while reset is held.
    always_comb begin
        if (!ap_rst_n || stall_s) begin
            req_ready = '0;
        end else begin
            req_ready = grant_s;
        end
    end

    // Priority pointer update on acceptance.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= next_ptr_s[ID_WIDTH-1:0];
        end
    end

    // Two-stage multiply pipeline; both stages freeze while stalled.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1_r  <= 1'b0;
            a1_r  <= '0;
            b1_r  <= '0;
            id1_r <= '0;
            v2_r  <= 1'b0;
            p2_r  <= '0;
            id2_r <= '0;
        end else if (!stall_s) begin
            v1_r <= accept_s;
            if (accept_s) begin
                a1_r  <= a_sel_s;
                b1_r  <= b_sel_s;
                id1_r <= grant_id_s;
            end
            v2_r  <= v1_r;
            p2_r  <= P_WIDTH'(a1_r) * P_WIDTH'(b1_r);
            id2_r <= id1_r;
        end
    end

    // Delivered-result counter, free-running modulo 2^32.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            op_count_r <= 32'd0;
        end else if (v2_r && rsp_ready) begin
            op_count_r <= op_count_r + 32'd1;
        end
    end

    assign rsp_valid = v2_r;
    assign rsp_p     = p2_r;
    assign rsp_id    = id2_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_conv_mul_arbiter.sv
// Directed table-driven bench for conv_mul_arbiter (NUM_REQ=4 defaults).
module tb_conv_mul_arbiter;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [83:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [28:0] rsp_p;
    logic [1:0]  rsp_id;
    logic [31:0] op_count;

    int total = 0;
    int bad   = 0;

    conv_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [83:0] b;
        logic        rdy;
        logic [3:0]  er;
        logic        ev;
        logic [28:0] ep;
        logic [1:0]  eid;
        logic [31:0] eo;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [83:0] pb(input int b0, input int b1, input int b2, input int b3);
        return {21'(b3), 21'(b2), 21'(b1), 21'(b0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] valid, input logic [31:0] a, input logic [83:0] b,
                                input logic rdy, input logic [3:0] er, input logic ev,
                                input int ep, input int eid, input int eo);
        vec_t v;
        v.valid = valid; v.a = a; v.b = b; v.rdy = rdy; v.er = er; v.ev = ev;
        v.ep = 29'(ep); v.eid = 2'(eid); v.eo = 32'(eo);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = v.rdy;
        #1;
        chk({nm, ".req_ready"}, 32'(req_ready), 32'(v.er));
        chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(v.ev));
        if (v.ev) begin
            chk({nm, ".rsp_p"}, 32'(rsp_p), 32'(v.ep));
            chk({nm, ".rsp_id"}, 32'(rsp_id), 32'(v.eid));
        end
        chk({nm, ".op_count"}, op_count, v.eo);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
            @(posedge ap_clk);
            #2;
        end
    endtask

    initial begin
        logic [31:0] a1, a2, a3, a4, a5;
        logic [83:0] b1, b2, b3, b4, b5;
        a1 = pa(0, 0, 3, 0);          b1 = pb(0, 0, 1000, 0);
        a2 = pa(255, 0, 0, 7);        b2 = pb(2097151, 0, 0, 11);
        a3 = pa(2, 0, 0, 0);          b3 = pb(5, 0, 0, 0);
        a4 = pa(4, 0, 0, 9);          b4 = pb(6, 0, 0, 10);
        a5 = pa(10, 11, 12, 13);      b5 = pb(1000, 1001, 1002, 1003);

        // single request from requester 2, then max operands, then fairness from ptr=1
        tbl.push_back(mk(4'b0100, a1, b1, 1'b1, 4'b0100, 1'b0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, a1, b1, 1'b1, 4'b0000, 1'b0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, a1, b1, 1'b1, 4'b0000, 1'b1, 3000, 2, 0));
        tbl.push_back(mk(4'b0000, a1, b1, 1'b1, 4'b0000, 1'b0, 0, 0, 1));
        tbl.push_back(mk(4'b0001, a2, b2, 1'b1, 4'b0001, 1'b0, 0, 0, 1));
        tbl.push_back(mk(4'b1000, a2, b2, 1'b1, 4'b1000, 1'b0, 0, 0, 1));
        tbl.push_back(mk(4'b0000, a2, b2, 1'b1, 4'b0000, 1'b1, 534773505, 0, 1));
        tbl.push_back(mk(4'b0000, a2, b2, 1'b1, 4'b0000, 1'b1, 77, 3, 2));
        tbl.push_back(mk(4'b0000, a2, b2, 1'b1, 4'b0000, 1'b0, 0, 0, 3));
        tbl.push_back(mk(4'b0001, a3, b3, 1'b1, 4'b0001, 1'b0, 0, 0, 3));
        tbl.push_back(mk(4'b1001, a4, b4, 1'b1, 4'b1000, 1'b0, 0, 0, 3));
        tbl.push_back(mk(4'b0001, a4, b4, 1'b1, 4'b0001, 1'b1, 10, 0, 3));
        tbl.push_back(mk(4'b0000, a4, b4, 1'b1, 4'b0000, 1'b1, 90, 3, 4));
        tbl.push_back(mk(4'b0000, a4, b4, 1'b1, 4'b0000, 1'b1, 24, 0, 5));
        tbl.push_back(mk(4'b0000, a4, b4, 1'b1, 4'b0000, 1'b0, 0, 0, 6));
        // all valid: scan resumes from ptr=1
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b0010, 1'b0, 0, 0, 6));
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b0100, 1'b0, 0, 0, 6));
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b1000, 1'b1, 11011, 1, 6));
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b0001, 1'b1, 12024, 2, 7));
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b0010, 1'b1, 13039, 3, 8));
        tbl.push_back(mk(4'b0000, a5, b5, 1'b1, 4'b0000, 1'b1, 10000, 0, 9));
        tbl.push_back(mk(4'b0000, a5, b5, 1'b1, 4'b0000, 1'b1, 11011, 1, 10));
        tbl.push_back(mk(4'b0000, a5, b5, 1'b1, 4'b0000, 1'b0, 0, 0, 11));
        // after mid-flight reset: contention from ptr=0, then 5-cycle backpressure
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b0001, 1'b0, 0, 0, 0));
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b0010, 1'b0, 0, 0, 0));
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b0100, 1'b1, 10000, 0, 0));
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b1000, 1'b1, 11011, 1, 1));
        for (int s = 0; s < 5; s++) begin
            tbl.push_back(mk(4'b1111, a5, b5, 1'b0, 4'b0000, 1'b1, 12024, 2, 2));
        end
        tbl.push_back(mk(4'b1111, a5, b5, 1'b1, 4'b0001, 1'b1, 12024, 2, 2));
        tbl.push_back(mk(4'b0000, a5, b5, 1'b1, 4'b0000, 1'b1, 13039, 3, 3));
        tbl.push_back(mk(4'b0000, a5, b5, 1'b1, 4'b0000, 1'b1, 10000, 0, 4));
        tbl.push_back(mk(4'b0000, a5, b5, 1'b1, 4'b0000, 1'b0, 0, 0, 5));

        ap_rst_n  = 1'b0;
        req_valid = 4'b1111;
        req_a     = a5;
        req_b     = b5;
        rsp_ready = 1'b1;
        #3;
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_p", 32'(rsp_p), 32'd0);
        chk("rst.rsp_id", 32'(rsp_id), 32'd0);
        chk("rst.op_count", op_count, 32'd0);
        @(posedge ap_clk);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;

        run(0, 23);

        // fill both stages (ids 2 then 3), then reset mid-flight
        apply_vec(mk(4'b1111, a5, b5, 1'b1, 4'b0100, 1'b0, 0, 0, 11), "mf0");
        @(posedge ap_clk);
        #2;
        apply_vec(mk(4'b1111, a5, b5, 1'b1, 4'b1000, 1'b0, 0, 0, 11), "mf1");
        @(posedge ap_clk);
        #2;
        apply_vec(mk(4'b0000, a5, b5, 1'b1, 4'b0000, 1'b1, 12024, 2, 11), "mf2");
        ap_rst_n = 1'b0;
        #1;
        chk("mfrst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mfrst.op_count", op_count, 32'd0);
        chk("mfrst.rsp_id", 32'(rsp_id), 32'd0);
        chk("mfrst.rsp_p", 32'(rsp_p), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("mfrst.req_ready", 32'(req_ready), 32'd0);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;

        run(23, tbl.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
